atm_txn_ctrl: RTL and testbench
===============================

# atm_txn_ctrl

Transaction sequencer for the ATM menu (check balance, withdraw cash, register card, change PIN). It owns a small on-chip account store, sequences one card session from insertion to completion, and enforces the PIN checks, lockout and timeout rules. It also produces a single completion report per session. It sits between the keypad/card-reader front end and the cash dispenser.

## Interface
- NUM_CARDS, 4, number of account slots; card_id width is CW = clog2(NUM_CARDS)
- BAL_W, 16, balance and amount width (unsigned)
- PIN_W, 16, PIN width
- INIT_BAL, 500, balance loaded at card registration
- MAX_TRIES, 3, consecutive wrong PINs before lockout
- TIMEOUT, 1000, idle cycles allowed in any wait state
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- card_in  in  1  single-cycle pulse: card inserted
- card_id  in  CW  card slot, sampled with card_in
- pin_valid  in  1  pin is valid this cycle
- pin  in  PIN_W  entered PIN
- op_valid  in  1  choice is valid this cycle
- choice  in  2  operation: 00 check balance, 01 withdraw, 10 register, 11 change PIN
- amt_valid  in  1  amount is valid this cycle
- amount  in  BAL_W  withdrawal amount
- cancel  in  1  abort the session
- busy  out  1  session in progress (state != IDLE)
- done_valid  out  1  single-cycle completion pulse
- done_status  out  3  0 OK, 1 BAD_PIN, 2 LOCKED, 3 NO_FUNDS, 4 TIMEOUT, 5 CANCEL, 6 ALREADY_REG, 7 ZERO_AMT
- balance_out  out  BAL_W  balance after the operation; holds until the next done_valid
- dispense  out  1  single-cycle pulse: dispense cash
- dispense_amt  out  BAL_W  amount to dispense; valid with dispense, holds afterwards

## Operation
- Per slot: registered flag, locked flag, PIN, balance. On reset: all flags 0, PIN 0, balance 0.
- States: IDLE, REG_PIN, WAIT_PIN, WAIT_OP, WAIT_AMT, WAIT_NEWPIN.
- IDLE:
  - card_in latches card_id.
  - Locked card: done LOCKED; stay in IDLE.
  - Unregistered card: go to REG_PIN.
  - Otherwise: go to WAIT_PIN and clear the try counter.
  - card_in is ignored in every other state.
- REG_PIN: pin_valid stores the PIN, sets registered, sets balance to INIT_BAL, issues done OK with balance_out = INIT_BAL, returns to IDLE.
- WAIT_PIN:
  - Matching pin: go to WAIT_OP.
  - Mismatching pin: increment the try counter.
  - When the counter reaches MAX_TRIES: set locked, issue done LOCKED, go to IDLE.
  - Otherwise: issue done BAD_PIN and stay in WAIT_PIN. This done is non-terminal and busy stays 1.
- WAIT_OP, on op_valid:
  - 00: done OK, balance_out = balance, go to IDLE.
  - 01: go to WAIT_AMT.
  - 10: done ALREADY_REG, go to IDLE.
  - 11: go to WAIT_NEWPIN.
- WAIT_AMT, on amt_valid:
  - amount == 0: done ZERO_AMT.
  - amount > balance: done NO_FUNDS; balance unchanged.
  - Otherwise: balance -= amount, pulse dispense with dispense_amt = amount, done OK with the new balance.
  - All three cases return to IDLE. Unsigned compare; amount == balance is allowed and leaves balance 0.
- WAIT_NEWPIN: pin_valid stores the new PIN, issues done OK, goes to IDLE.
- In any wait state, cancel issues done CANCEL and goes to IDLE. cancel has priority over any simultaneous valid input.
- Valid inputs not relevant to the current state are ignored.

## Timing
- Reset values: busy 0, done_valid 0, done_status 0, balance_out 0, dispense 0, dispense_amt 0.
- Every output is registered. done_valid, dispense and the state change appear in the cycle after the accepting input edge.
- busy falls in the same cycle a terminal done_valid is asserted.
- A new card_in is accepted in that same cycle.
- Timeout counter:
  - Reloads on entry to each wait state and on every accepted input.
  - After TIMEOUT consecutive cycles without an accepted input, issue done TIMEOUT and go to IDLE.
  - Account state is unchanged except for any lock already set.
- The try counter is per session and clears on every card_in.
- The lock persists until reset.
- Reset asserted mid-session drops the session immediately. No done_valid and no dispense are issued.

## Test plan
- Register slot 2 with PIN 0x1234 -> done OK, balance_out 500. Re-insert, PIN 0x1234, choice 00 -> done OK, balance_out 500.
- Slot 2, withdraw 200 -> dispense pulse with dispense_amt 200, done OK, balance_out 300. Withdraw 301 -> NO_FUNDS, balance_out 300. Withdraw 0 -> ZERO_AMT.
- Slot 2, three wrong PINs -> BAD_PIN, BAD_PIN, then LOCKED with busy 0. Re-insert slot 2 -> immediate done LOCKED.
- Slot 1 registered: change PIN to 0x0042 -> done OK. Old PIN now gives BAD_PIN; 0x0042 reaches WAIT_OP. choice 10 -> ALREADY_REG.
- In WAIT_AMT, drive cancel and amt_valid together -> CANCEL, no dispense, balance unchanged. Idle TIMEOUT cycles in WAIT_OP -> TIMEOUT.
- Deassert rst_n while in WAIT_AMT -> all outputs 0 and all slots unregistered.

Source files
------------

// File: rtl/atm_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : atm_txn_ctrl
// Summary  : ATM card-session sequencer with a small on-chip account store.
//            Handles registration, PIN check with lockout, balance query,
//            withdrawal, PIN change, cancel and idle timeout, and emits one
//            registered completion report per operation.
// Revision : 1.0 - initial release
// ============================================================================
module atm_txn_ctrl #(
    parameter int NUM_CARDS = 4,
    parameter int BAL_W     = 16,
    parameter int PIN_W     = 16,
    parameter int INIT_BAL  = 500,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 1000,
    localparam int CW       = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             card_in,
    input  logic [CW-1:0]    card_id,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    input  logic             op_valid,
    input  logic [1:0]       choice,
    input  logic             amt_valid,
    input  logic [BAL_W-1:0] amount,
    input  logic             cancel,
    output logic             busy,
    output logic             done_valid,
    output logic [2:0]       done_status,
    output logic [BAL_W-1:0] balance_out,
    output logic             dispense,
    output logic [BAL_W-1:0] dispense_amt
);

    // Watchdog counts 0..TIMEOUT-1, try counter counts 0..MAX_TRIES-1
    localparam int TW = (TIMEOUT > 1)   ? $clog2(TIMEOUT)   : 1;
    localparam int RW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [TW-1:0]    c_TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0]    c_TRY_LAST = RW'(MAX_TRIES - 1);
    localparam logic [BAL_W-1:0] c_INIT_BAL = BAL_W'(INIT_BAL);

    localparam logic [2:0] c_ST_OK          = 3'd0;
    localparam logic [2:0] c_ST_BAD_PIN     = 3'd1;
    localparam logic [2:0] c_ST_LOCKED      = 3'd2;
    localparam logic [2:0] c_ST_NO_FUNDS    = 3'd3;
    localparam logic [2:0] c_ST_TIMEOUT     = 3'd4;
    localparam logic [2:0] c_ST_CANCEL      = 3'd5;
    localparam logic [2:0] c_ST_ALREADY_REG = 3'd6;
    localparam logic [2:0] c_ST_ZERO_AMT    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_REG_PIN     = 3'd1,
        S_WAIT_PIN    = 3'd2,
        S_WAIT_OP     = 3'd3,
        S_WAIT_AMT    = 3'd4,
        S_WAIT_NEWPIN = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CW-1:0]    r_card;
    logic [RW-1:0]    r_tries;
    logic [TW-1:0]    r_tmo;

    logic             r_reg  [NUM_CARDS];
    logic             r_lock [NUM_CARDS];
    logic [PIN_W-1:0] r_pin  [NUM_CARDS];
    logic [BAL_W-1:0] r_bal  [NUM_CARDS];

    // ------------------------------------------------------------------
    // Combinational decisions
    // ------------------------------------------------------------------
    state_t           w_state_nxt;
    logic             w_done;
    logic [2:0]       w_status;
    logic [BAL_W-1:0] w_bal_rpt;
    logic             w_disp;
    logic             w_card_ld;
    logic             w_try_clr;
    logic             w_try_inc;
    logic             w_tmo_rld;
    logic             w_wr_pin;
    logic             w_set_reg;
    logic             w_set_lock;
    logic             w_bal_wr;
    logic [BAL_W-1:0] w_bal_new;

    logic [PIN_W-1:0] w_cur_pin;
    logic [BAL_W-1:0] w_cur_bal;
    logic             w_tmo_hit;

    assign w_cur_pin = r_pin[r_card];
    assign w_cur_bal = r_bal[r_card];
    assign w_tmo_hit = (r_tmo == c_TMO_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle action decode; cancel beats inputs, inputs beat timeout
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_status    = c_ST_OK;
        w_bal_rpt   = w_cur_bal;
        w_disp      = 1'b0;
        w_card_ld   = 1'b0;
        w_try_clr   = 1'b0;
        w_try_inc   = 1'b0;
        w_tmo_rld   = 1'b0;
        w_wr_pin    = 1'b0;
        w_set_reg   = 1'b0;
        w_set_lock  = 1'b0;
        w_bal_wr    = 1'b0;
        w_bal_new   = w_cur_bal - amount;

        if (r_state == S_IDLE) begin
            if (card_in) begin
                w_card_ld = 1'b1;
                w_try_clr = 1'b1;
                w_tmo_rld = 1'b1;
                if (r_lock[card_id]) begin
                    w_done    = 1'b1;
                    w_status  = c_ST_LOCKED;
                    w_bal_rpt = r_bal[card_id];
                end else if (!r_reg[card_id]) begin
                    w_state_nxt = S_REG_PIN;
                end else begin
                    w_state_nxt = S_WAIT_PIN;
                end
            end
        end else if (cancel) begin
            w_done      = 1'b1;
            w_status    = c_ST_CANCEL;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_REG_PIN: begin
                    if (pin_valid) begin
                        w_tmo_rld   = 1'b1;
                        w_wr_pin    = 1'b1;
                        w_set_reg   = 1'b1;
                        w_bal_wr    = 1'b1;
                        w_bal_new   = c_INIT_BAL;
                        w_done      = 1'b1;
                        w_status    = c_ST_OK;
                        w_bal_rpt   = c_INIT_BAL;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_WAIT_PIN: begin
                    if (pin_valid) begin
                        w_tmo_rld = 1'b1;
                        if (pin == w_cur_pin) begin
                            w_state_nxt = S_WAIT_OP;
                        end else if (r_tries == c_TRY_LAST) begin
                            w_set_lock  = 1'b1;
                            w_done      = 1'b1;
                            w_status    = c_ST_LOCKED;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_try_inc = 1'b1;
                            w_done    = 1'b1;
                            w_status  = c_ST_BAD_PIN;
                        end
                    end
                end
                S_WAIT_OP: begin
                    if (op_valid) begin
                        w_tmo_rld = 1'b1;
                        case (choice)
                            2'b00: begin
                                w_done      = 1'b1;
                                w_status    = c_ST_OK;
                                w_state_nxt = S_IDLE;
                            end
                            2'b01: w_state_nxt = S_WAIT_AMT;
                            2'b10: begin
                                w_done      = 1'b1;
                                w_status    = c_ST_ALREADY_REG;
                                w_state_nxt = S_IDLE;
                            end
                            default: w_state_nxt = S_WAIT_NEWPIN;
                        endcase
                    end
                end
                S_WAIT_AMT: begin
                    if (amt_valid) begin
                        w_tmo_rld   = 1'b1;
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                        if (amount == '0) begin
                            w_status = c_ST_ZERO_AMT;
                        end else if (amount > w_cur_bal) begin
                            w_status = c_ST_NO_FUNDS;
                        end else begin
                            w_status  = c_ST_OK;
                            w_bal_wr  = 1'b1;
                            w_disp    = 1'b1;
                            w_bal_rpt = w_cur_bal - amount;
                        end
                    end
                end
                S_WAIT_NEWPIN: begin
                    if (pin_valid) begin
                        w_tmo_rld   = 1'b1;
                        w_wr_pin    = 1'b1;
                        w_done      = 1'b1;
                        w_status    = c_ST_OK;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase

            if (!w_tmo_rld && w_tmo_hit && r_state != S_IDLE) begin
                w_done      = 1'b1;
                w_status    = c_ST_TIMEOUT;
                w_state_nxt = S_IDLE;
            end
        end
    end

    // Session card latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_card <= '0;
        end else if (w_card_ld) begin
            r_card <= card_id;
        end
    end

    // Consecutive wrong-PIN counter for the current session
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tries <= '0;
        end else if (w_try_clr) begin
            r_tries <= '0;
        end else if (w_try_inc) begin
            r_tries <= r_tries + 1'b1;
        end
    end

    // Idle-cycle watchdog; held at zero outside wait states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (w_tmo_rld || r_state == S_IDLE) begin
            r_tmo <= '0;
        end else if (!w_tmo_hit) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Account store: one flag/PIN/balance set per slot, written for the session card
    for (genvar g = 0; g < NUM_CARDS; g++) begin : g_slot
        logic w_sel;
        assign w_sel = (r_card == CW'(g));

        // Slot state update
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_reg[g]  <= 1'b0;
                r_lock[g] <= 1'b0;
                r_pin[g]  <= '0;
                r_bal[g]  <= '0;
            end else if (w_sel) begin
                if (w_set_reg) begin
                    r_reg[g] <= 1'b1;
                end
                if (w_set_lock) begin
                    r_lock[g] <= 1'b1;
                end
                if (w_wr_pin) begin
                    r_pin[g] <= pin;
                end
                if (w_bal_wr) begin
                    r_bal[g] <= w_bal_new;
                end
            end
        end
    end

    // Registered outputs; report fields and dispense amount hold between events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= 1'b0;
            done_valid   <= 1'b0;
            done_status  <= 3'd0;
            balance_out  <= '0;
            dispense     <= 1'b0;
            dispense_amt <= '0;
        end else begin
            busy       <= (w_state_nxt != S_IDLE);
            done_valid <= w_done;
            dispense   <= w_disp;
            if (w_done) begin
                done_status <= w_status;
                balance_out <= w_bal_rpt;
            end
            if (w_disp) begin
                dispense_amt <= amount;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_atm_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_txn_ctrl
// Summary  : Self-checking bench for atm_txn_ctrl: directed scenarios with
//            literal expectations, then randomized sessions compared every
//            cycle against an account/session model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_txn_ctrl;

    localparam int NC  = 4;
    localparam int IB  = 500;
    localparam int MT  = 3;
    localparam int TMO = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        card_in = 1'b0;
    logic [1:0]  card_id = 2'd0;
    logic        pin_valid = 1'b0;
    logic [15:0] pin = 16'd0;
    logic        op_valid = 1'b0;
    logic [1:0]  choice = 2'd0;
    logic        amt_valid = 1'b0;
    logic [15:0] amount = 16'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done_valid;
    logic [2:0]  done_status;
    logic [15:0] balance_out;
    logic        dispense;
    logic [15:0] dispense_amt;

    atm_txn_ctrl #(
        .NUM_CARDS (NC),
        .BAL_W     (16),
        .PIN_W     (16),
        .INIT_BAL  (IB),
        .MAX_TRIES (MT),
        .TIMEOUT   (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .card_in      (card_in),
        .card_id      (card_id),
        .pin_valid    (pin_valid),
        .pin          (pin),
        .op_valid     (op_valid),
        .choice       (choice),
        .amt_valid    (amt_valid),
        .amount       (amount),
        .cancel       (cancel),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_status  (done_status),
        .balance_out  (balance_out),
        .dispense     (dispense),
        .dispense_amt (dispense_amt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: accounts plus "what the session is waiting for"
    // ph: 0 no session, 1 awaiting registration PIN, 2 awaiting PIN,
    //     3 awaiting menu choice, 4 awaiting amount, 5 awaiting new PIN
    // ------------------------------------------------------------------
    int ph, m_card, m_wrong, m_idle;
    int m_reg [NC];
    int m_lock[NC];
    int m_pin [NC];
    int m_bal [NC];
    int e_busy, e_done, e_status, e_bal, e_disp, e_damt;

    task automatic report(input int st);
        e_done   = 1;
        e_status = st;
        e_bal    = m_bal[m_card];
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ph = 0; m_card = 0; m_wrong = 0; m_idle = 0;
                for (int i = 0; i < NC; i++) begin
                    m_reg[i] = 0; m_lock[i] = 0; m_pin[i] = 0; m_bal[i] = 0;
                end
                e_busy = 0; e_done = 0; e_status = 0; e_bal = 0; e_disp = 0; e_damt = 0;
            end else begin
                int took;
                took   = 0;
                e_done = 0;
                e_disp = 0;
                if (ph == 0) begin
                    if (card_in) begin
                        m_card  = int'(card_id);
                        m_wrong = 0;
                        m_idle  = 0;
                        if (m_lock[m_card] != 0) report(2);
                        else ph = (m_reg[m_card] != 0) ? 2 : 1;
                    end
                end else if (cancel) begin
                    report(5);
                    ph = 0;
                end else begin
                    if (ph == 1 && pin_valid) begin
                        took = 1;
                        m_pin[m_card] = int'(pin);
                        m_reg[m_card] = 1;
                        m_bal[m_card] = IB;
                        report(0);
                        ph = 0;
                    end else if (ph == 2 && pin_valid) begin
                        took = 1;
                        if (int'(pin) == m_pin[m_card]) begin
                            ph = 3;
                        end else begin
                            m_wrong++;
                            if (m_wrong >= MT) begin
                                m_lock[m_card] = 1;
                                report(2);
                                ph = 0;
                            end else begin
                                report(1);
                            end
                        end
                    end else if (ph == 3 && op_valid) begin
                        took = 1;
                        if (choice == 2'd0) begin report(0); ph = 0; end
                        else if (choice == 2'd1) ph = 4;
                        else if (choice == 2'd2) begin report(6); ph = 0; end
                        else ph = 5;
                    end else if (ph == 4 && amt_valid) begin
                        took = 1;
                        if (amount == 16'd0) begin
                            report(7);
                        end else if (int'(amount) > m_bal[m_card]) begin
                            report(3);
                        end else begin
                            m_bal[m_card] = m_bal[m_card] - int'(amount);
                            e_disp = 1;
                            e_damt = int'(amount);
                            report(0);
                        end
                        ph = 0;
                    end else if (ph == 5 && pin_valid) begin
                        took = 1;
                        m_pin[m_card] = int'(pin);
                        report(0);
                        ph = 0;
                    end
                    if (took != 0) begin
                        m_idle = 0;
                    end else begin
                        m_idle++;
                        if (m_idle == TMO) begin
                            report(4);
                            ph = 0;
                        end
                    end
                end
                e_busy = (ph != 0) ? 1 : 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("busy",         32'(busy),         32'(e_busy));
            check("done_valid",   32'(done_valid),   32'(e_done));
            check("done_status",  32'(done_status),  32'(e_status));
            check("balance_out",  32'(balance_out),  32'(e_bal));
            check("dispense",     32'(dispense),     32'(e_disp));
            check("dispense_amt", 32'(dispense_amt), 32'(e_damt));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        card_in = 1'b0; pin_valid = 1'b0; op_valid = 1'b0; amt_valid = 1'b0; cancel = 1'b0;
    endtask

    // One input cycle; returns on the negedge where its result is visible
    task automatic act(input int kind, input int val, input bit with_cancel);
        @(negedge clk);
        clear_inputs();
        case (kind)
            0: begin card_in = 1'b1; card_id = val[1:0]; end
            1: begin pin_valid = 1'b1; pin = val[15:0]; end
            2: begin op_valid = 1'b1; choice = val[1:0]; end
            3: begin amt_valid = 1'b1; amount = val[15:0]; end
            default: ;
        endcase
        cancel = with_cancel;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic expect_done(input string name, input int st, input int bal);
        check({name, "_valid"},  32'(done_valid),  32'd1);
        check({name, "_status"}, 32'(done_status), 32'(st));
        check({name, "_bal"},    32'(balance_out), 32'(bal));
    endtask

    task automatic login(input int slot, input int p);
        act(0, slot, 1'b0);
        act(1, p, 1'b0);
    endtask

    initial begin
        int cyc;
        int sel;
        logic [15:0] ptab [4];
        ptab[0] = 16'h1234; ptab[1] = 16'h0042; ptab[2] = 16'h0099; ptab[3] = 16'h0007;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done_valid), 32'd0);
        check("rst_status", 32'(done_status), 32'd0);
        check("rst_bal", 32'(balance_out), 32'd0);
        check("rst_disp", 32'(dispense), 32'd0);
        check("rst_damt", 32'(dispense_amt), 32'd0);
        #2 rst_n = 1'b1;

        // Registration and balance query
        act(0, 2, 1'b0);
        check("reg_busy", 32'(busy), 32'd1);
        act(1, 16'h1234, 1'b0);
        expect_done("reg2", 0, 500);
        check("reg2_busy", 32'(busy), 32'd0);
        login(2, 16'h1234);
        act(2, 0, 1'b0);
        expect_done("query", 0, 500);

        // Withdrawals
        login(2, 16'h1234); act(2, 1, 1'b0); act(3, 200, 1'b0);
        check("wd_disp", 32'(dispense), 32'd1);
        check("wd_damt", 32'(dispense_amt), 32'd200);
        expect_done("wd200", 0, 300);
        login(2, 16'h1234); act(2, 1, 1'b0); act(3, 301, 1'b0);
        check("nf_disp", 32'(dispense), 32'd0);
        expect_done("wd301", 3, 300);
        login(2, 16'h1234); act(2, 1, 1'b0); act(3, 0, 1'b0);
        expect_done("wd0", 7, 300);

        // PIN change on slot 1
        act(0, 1, 1'b0); act(1, 16'h0099, 1'b0);
        expect_done("reg1", 0, 500);
        login(1, 16'h0099); act(2, 3, 1'b0); act(1, 16'h0042, 1'b0);
        expect_done("newpin", 0, 500);
        login(1, 16'h0099);
        expect_done("oldpin", 1, 500);
        check("oldpin_busy", 32'(busy), 32'd1);
        act(1, 16'h0042, 1'b0);
        check("newpin_nodone", 32'(done_valid), 32'd0);
        check("newpin_busy", 32'(busy), 32'd1);
        act(2, 2, 1'b0);
        expect_done("already", 6, 500);

        // Cancel wins over a simultaneous amount
        login(2, 16'h1234); act(2, 1, 1'b0); act(3, 100, 1'b1);
        expect_done("cancel", 5, 300);
        check("cancel_disp", 32'(dispense), 32'd0);

        // Timeout in menu wait
        login(2, 16'h1234);
        cyc = 0;
        for (int i = 1; i <= TMO + 5; i++) begin
            @(negedge clk);
            cyc = i;
            if (done_valid) break;
        end
        check("tmo_cycles", 32'(cyc), 32'(TMO));
        expect_done("tmo", 4, 300);

        // Lockout
        login(2, 16'h1111);
        expect_done("bad1", 1, 300);
        act(1, 16'h2222, 1'b0);
        expect_done("bad2", 1, 300);
        act(1, 16'h3333, 1'b0);
        expect_done("lock", 2, 300);
        check("lock_busy", 32'(busy), 32'd0);
        act(0, 2, 1'b0);
        expect_done("relock", 2, 300);
        check("relock_busy", 32'(busy), 32'd0);

        // Reset mid-withdrawal
        act(0, 3, 1'b0); act(1, 16'h0007, 1'b0);
        login(3, 16'h0007); act(2, 1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done_valid), 32'd0);
        check("mid_rst_bal", 32'(balance_out), 32'd0);
        check("mid_rst_damt", 32'(dispense_amt), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        act(0, 3, 1'b0);
        check("unreg3_busy", 32'(busy), 32'd1);
        check("unreg3_nodone", 32'(done_valid), 32'd0);
        act(4, 0, 1'b1);
        expect_done("unreg3_cancel", 5, 0);
        act(0, 2, 1'b0);
        check("unreg2_busy", 32'(busy), 32'd1);
        act(4, 0, 1'b1);

        // Randomized sessions
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                clear_inputs();
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
                continue;
            end
            if ($urandom_range(0, 79) == 0) begin
                clear_inputs();
                repeat (TMO + 3) @(negedge clk);
            end
            card_in   = ($urandom_range(0, 3) == 0);
            card_id   = 2'($urandom_range(0, 3));
            pin_valid = ($urandom_range(0, 2) == 0);
            pin       = ($urandom_range(0, 3) != 0) ? 16'(m_pin[m_card]) : ptab[$urandom_range(0, 3)];
            op_valid  = ($urandom_range(0, 2) == 0);
            choice    = 2'($urandom_range(0, 3));
            amt_valid = ($urandom_range(0, 2) == 0);
            sel       = int'($urandom_range(0, 3));
            case (sel)
                0: amount = 16'd0;
                1: amount = 16'(m_bal[m_card]);
                2: amount = 16'(m_bal[m_card] + 1);
                default: amount = 16'($urandom_range(1, 300));
            endcase
            cancel    = ($urandom_range(0, 24) == 0);
        end
        @(negedge clk);
        clear_inputs();
        repeat (TMO + 5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
